// File: rtl/aes_key_g_if.sv
// Handshake bundle for the AES-128 key-expansion g-function helper.
interface aes_key_g_if;
  logic        enable;
  logic [31:0] inputVal;
  logic [3:0]  roundNum;
  logic [31:0] outputVal;
  logic        done;

  modport master (output enable, inputVal, roundNum, input outputVal, done);
  modport slave  (input enable, inputVal, roundNum, output outputVal, done);
endinterface

// File: rtl/aes_key_g.sv
// AES-128 key-expansion g-function: RotWord, SubWord, rcon XOR into the top byte.
// AES_KEY_G_PARALLEL_SBOX_EN: four S-boxes, single-cycle CALC; otherwise one shared S-box over four cycles.
module aes_key_g (
  input logic        clk,
  input logic        n_rst,
  aes_key_g_if.slave kg
);

  // Forward S-box, entry 0 in the most-significant byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_ROM[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_KEY_G_PARALLEL_SBOX_EN
  typedef enum logic {IDLE, CALC} state_t;
`else
  typedef enum logic [2:0] {IDLE, SUB0, SUB1, SUB2, SUB3} state_t;
`endif

  state_t      state, state_nxt;
  logic        capture, finish;
  logic [31:0] cap_word;
  logic [3:0]  cap_round;
  logic [31:0] result;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
`ifdef AES_KEY_G_PARALLEL_SBOX_EN
      IDLE: if (kg.enable) begin
        capture   = 1'b1;
        state_nxt = CALC;
      end
      CALC: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
`else
      IDLE: if (kg.enable) begin
        capture   = 1'b1;
        state_nxt = SUB0;
      end
      SUB0: state_nxt = SUB1;
      SUB1: state_nxt = SUB2;
      SUB2: state_nxt = SUB3;
      SUB3: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AES_KEY_G_PARALLEL_SBOX_EN
  assign result = {sbox(cap_word[23:16]) ^ rcon(cap_round), sbox(cap_word[15:8]),
                   sbox(cap_word[7:0]), sbox(cap_word[31:24])};
`else
  logic [7:0]  sub_in, sub_out;
  logic [23:0] stage;

  // Rotated byte order a1, a2, a3, a0; a0 goes straight into the result on SUB3.
  always_comb begin
    sub_in = cap_word[31:24];
    case (state)
      SUB0:    sub_in = cap_word[23:16];
      SUB1:    sub_in = cap_word[15:8];
      SUB2:    sub_in = cap_word[7:0];
      default: sub_in = cap_word[31:24];
    endcase
  end

  assign sub_out = sbox(sub_in);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stage <= '0;
    end else begin
      case (state)
        SUB0:    stage[23:16] <= sub_out;
        SUB1:    stage[15:8]  <= sub_out;
        SUB2:    stage[7:0]   <= sub_out;
        default: stage        <= stage;
      endcase
    end
  end

  assign result = {stage[23:16] ^ rcon(cap_round), stage[15:0], sub_out};
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cap_word     <= '0;
      cap_round    <= '0;
      kg.outputVal <= '0;
      kg.done      <= 1'b0;
    end else begin
      if (capture) begin
        cap_word  <= kg.inputVal;
        cap_round <= kg.roundNum;
      end
      kg.done <= finish;
      if (finish) kg.outputVal <= result;
    end
  end

endmodule

// File: tb/tb_aes_key_g.sv
// Randomized scoreboard bench for aes_key_g against a GF(2^8) reference model.
module tb_aes_key_g;

`ifdef AES_KEY_G_PARALLEL_SBOX_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic        tb_clk = 1'b0;
  logic        n_rst  = 1'b0;
  aes_key_g_if kg ();

  aes_key_g dut (.clk(tb_clk), .n_rst(n_rst), .kg(kg));

  always #5 tb_clk = ~tb_clk;

  exp_t        sb[$];
  logic [7:0]  ref_sbox [256];
  int          checks = 0, errors = 0;
  int          cyc = 0, busy = 0;
  logic [31:0] hold = '0;
  logic        end_req = 1'b0, end_done = 1'b0;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = '0;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input logic [3:0] r);
    logic [7:0] v = 8'h01;
    if (r == 0 || r > 10) return 8'h00;
    for (int i = 1; i < int'(r); i++) v = xtime(v);
    return v;
  endfunction

  function automatic logic [31:0] g_ref(input logic [31:0] w, input logic [3:0] r);
    logic [31:0] rot = {w[23:0], w[31:24]};
    return {ref_sbox[rot[31:24]] ^ rcon_ref(r), ref_sbox[rot[23:16]],
            ref_sbox[rot[15:8]], ref_sbox[rot[7:0]]};
  endfunction

  initial for (int i = 0; i < 256; i++) ref_sbox[i] = sbox_calc(8'(i));

  // Acceptance model: a request is taken when idle, then the block is deaf for LAT edges.
  always @(posedge tb_clk or negedge n_rst) begin
    if (!n_rst) begin
      sb.delete();
      busy = 0;
    end else begin
      cyc++;
      if (busy > 0) busy--;
      else if (kg.enable) begin
        sb.push_back('{val: g_ref(kg.inputVal, kg.roundNum), cyc: cyc});
        busy = LAT;
      end
    end
  end

  always @(negedge tb_clk) begin
    exp_t e;
    if (kg.done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done outputVal=%h", kg.outputVal);
      end else begin
        e = sb.pop_front();
        if (kg.outputVal !== e.val) begin
          errors++;
          $display("FAIL result got=%h exp=%h", kg.outputVal, e.val);
        end
        checks++;
        if (cyc != e.cyc + LAT) begin
          errors++;
          $display("FAIL latency got=%0d exp=%0d", cyc - e.cyc, LAT);
        end
        hold = e.val;
      end
    end else begin
      if (!n_rst) hold = '0;
      checks++;
      if (kg.outputVal !== hold || kg.done !== 1'b0) begin
        errors++;
        $display("FAIL hold outputVal=%h exp=%h done=%b", kg.outputVal, hold, kg.done);
      end
    end
    if (end_req && !end_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL missing_done pending=%0d exp=0", sb.size());
      end
      end_done = 1'b1;
    end
  end

  task automatic op(input logic [31:0] w, input logic [3:0] r);
    @(negedge tb_clk);
    kg.enable = 1'b1; kg.inputVal = w; kg.roundNum = r;
    @(negedge tb_clk);
    kg.enable = 1'b0; kg.inputVal = $urandom; kg.roundNum = 4'($urandom);
    repeat (LAT + 2) @(negedge tb_clk);
  endtask

  initial begin
    kg.enable = 1'b0; kg.inputVal = '0; kg.roundNum = '0;
    repeat (3) @(negedge tb_clk);
    n_rst = 1'b1;
    repeat (2) @(negedge tb_clk);

    op(32'hAAAAAAAA, 4'd1);
    op(32'h00000000, 4'd4);
    op(32'h00000000, 4'd10);
    op(32'h00000000, 4'd0);
    op(32'h12345678, 4'd5);
    op(32'hFFFFFFFF, 4'd3);
    op(32'h00000000, 4'd15);

    // Second request lands at E2 with different data.
    @(negedge tb_clk);
    kg.enable = 1'b1; kg.inputVal = 32'h01020304; kg.roundNum = 4'd2;
    @(negedge tb_clk); kg.enable = 1'b0;
    @(negedge tb_clk);
    kg.enable = 1'b1; kg.inputVal = 32'hDEADBEEF; kg.roundNum = 4'd9;
    @(negedge tb_clk); kg.enable = 1'b0;
    repeat (LAT + 3) @(negedge tb_clk);

    // Enable held high for two operations, data changing every cycle.
    for (int i = 0; i < 2 * (LAT + 1); i++) begin
      kg.enable = 1'b1; kg.inputVal = $urandom; kg.roundNum = 4'($urandom_range(1, 10));
      @(negedge tb_clk);
    end
    kg.enable = 1'b0;
    repeat (LAT + 3) @(negedge tb_clk);

    // Reset just after the capture edge: no done may follow.
    kg.enable = 1'b1; kg.inputVal = 32'hCAFEF00D; kg.roundNum = 4'd7;
    @(posedge tb_clk);
    #2 n_rst = 1'b0; kg.enable = 1'b0;
    repeat (3) @(negedge tb_clk);
    n_rst = 1'b1;
    repeat (LAT + 3) @(negedge tb_clk);

    for (int i = 0; i < 400; i++) begin
      kg.enable   = ($urandom_range(0, 2) == 0);
      kg.inputVal = $urandom;
      kg.roundNum = 4'($urandom);
      @(negedge tb_clk);
    end
    kg.enable = 1'b0;
    repeat (LAT + 4) @(negedge tb_clk);

    end_req = 1'b1;
    repeat (2) @(negedge tb_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
